// File: rtl/operand_capture.sv
// Operand input stage for the multiplier: debounces operand changes over SETTLE
// cycles, launches the multiplier with a one-cycle start and waits for done.
module operand_capture #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned SETTLE = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lock_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             done,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             start,
  output logic             busy,
  output logic             changed,
  output logic [CNT_W-1:0] launches
);

  localparam int unsigned SettleW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [SettleW-1:0] CntLast = SettleW'((SETTLE > 0) ? SETTLE - 1 : 0);

  typedef enum logic [1:0] {StIdle, StSettle, StBusy} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   a_smp_q, a_smp_d, b_smp_q, b_smp_d;
  logic [SettleW-1:0] cnt_q, cnt_d;
  logic               start_q, start_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   launches_q, launches_d;
  logic               launch;
  logic               smp_match;

  assign changed   = (a_in != a_q) || (b_in != b_q);
  assign smp_match = (a_in == a_smp_q) && (b_in == b_smp_q);

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    a_smp_d    = a_smp_q;
    b_smp_d    = b_smp_q;
    cnt_d      = cnt_q;
    start_d    = 1'b0;
    busy_d     = busy_q;
    launches_d = launches_q;
    launch     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!lock_in && changed) begin
          if (SETTLE == 0) begin
            launch = 1'b1;
          end else begin
            a_smp_d = a_in;
            b_smp_d = b_in;
            cnt_d   = '0;
            state_d = StSettle;
          end
        end
      end
      StSettle: begin
        // Lock wins over everything, including a launch due on this edge.
        if (lock_in || !changed) begin
          state_d = StIdle;
        end else if (!smp_match) begin
          a_smp_d = a_in;
          b_smp_d = b_in;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          launch = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StBusy: begin
        // done coinciding with start is dropped.
        if (!start_q && done) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (launch) begin
      a_d        = (state_q == StSettle) ? a_smp_q : a_in;
      b_d        = (state_q == StSettle) ? b_smp_q : b_in;
      start_d    = 1'b1;
      busy_d     = 1'b1;
      launches_d = launches_q + 1'b1;
      state_d    = StBusy;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      a_smp_q    <= '0;
      b_smp_q    <= '0;
      cnt_q      <= '0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      launches_q <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      a_smp_q    <= a_smp_d;
      b_smp_q    <= b_smp_d;
      cnt_q      <= cnt_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      launches_q <= launches_d;
    end
  end

  assign a_out    = a_q;
  assign b_out    = b_q;
  assign start    = start_q;
  assign busy     = busy_q;
  assign launches = launches_q;

endmodule

// File: doc/operand_capture.md
# operand_capture

Parametrised operand input stage for the multiplier datapath. It holds two WIDTH-bit operands and filters input glitches by requiring new operand values to stay stable for SETTLE cycles before capturing them. It then launches the multiplier with a one-cycle start pulse and ignores the inputs until the multiplier reports done. It also keeps a wrapping count of launches and provides a combinational change flag for status logic.

## Interface
- WIDTH, 8, operand width in bits (≥1)
- SETTLE, 4, consecutive matching cycles required after a change is first seen (0–255); 0 means capture on first sight
- CNT_W, 8, width of the launch counter (≥1)

- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- lock_in  input  1  external hold; while 1, no new capture is started and any settle in progress is discarded
- a_in, b_in  input  WIDTH  raw operands
- done  input  1  multiplier completion pulse; sampled only in BUSY
- a_out, b_out  output  WIDTH  registered, captured operands to the multiplier
- start  output  1  registered one-cycle launch pulse
- busy  output  1  registered; 1 in BUSY
- changed  output  1  combinational: (a_in != a_out) || (b_in != b_out)
- launches  output  CNT_W  registered count of start pulses; wraps modulo 2^CNT_W

## Operation
- Internal registers: sample registers a_smp/b_smp (WIDTH each) and a settle counter cnt, clog2(SETTLE+1) bits, minimum 1 bit.
- FSM states: IDLE, SETTLE, BUSY.
- IDLE:
  - If lock_in=0 and changed=1 with SETTLE>0: load a_smp/b_smp from a_in/b_in, set cnt=0, go to SETTLE.
  - If lock_in=0 and changed=1 with SETTLE=0: launch directly (see launch action).
  - Otherwise stay in IDLE; outputs hold.
- SETTLE, evaluated in this priority order at each edge:
  1. lock_in=1: go to IDLE; sample discarded; outputs unchanged.
  2. Inputs equal a_out/b_out (change reverted): go to IDLE, no launch.
  3. Inputs differ from a_smp/b_smp: reload the sample, set cnt=0, stay in SETTLE.
  4. Inputs match the sample and cnt==SETTLE-1: perform the launch action.
  5. Inputs match the sample otherwise: cnt+1.
- Launch action, all at one edge:
  - a_out/b_out load the matched value. That is a_smp/b_smp, or a_in/b_in when SETTLE=0.
  - start is set to 1.
  - launches increments.
  - Next state is BUSY.
- BUSY:
  - busy=1.
  - start clears to 0 on the first BUSY edge.
  - done is ignored while start=1. On the first edge with start=0 and done=1, go to IDLE and clear busy.
  - a_in, b_in and lock_in are ignored; a_out/b_out hold.
- changed remains live in every state, including BUSY.
- launches wraps from 2^CNT_W-1 to 0 without a flag.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, a_out=b_out=0, a_smp=b_smp=0, cnt=0, start=0, busy=0, launches=0. changed then reflects a_in/b_in against 0.
- Reset release is synchronous in effect; the first active edge after rst rises evaluates IDLE.
- Latency: a change is first seen at edge k (IDLE→SETTLE). If inputs hold, the launch edge is k+SETTLE. a_out, start and busy are all visible after that edge. start is high for exactly one cycle.
- SETTLE=0: the launch occurs at edge k.
- Minimum IDLE-to-IDLE turnaround: SETTLE+2 edges. The earliest done that is accepted is the one in the cycle after start.
- A done pulse in the cycle where start=1 is dropped. The multiplier must hold done or pulse it later.
- Reset mid-operation, in any state, returns immediately to reset values. No start pulse is generated by reset.
- lock_in rising in the same cycle as the would-be launch edge: the launch is suppressed; lock has priority.

## Test plan
- Reset/idle (WIDTH=8, SETTLE=4): assert rst=0 with a_in=0x12 → a_out=b_out=0, start=busy=0, launches=0, changed=1. Release reset with a_in=b_in=0 → changed=0 and state stays IDLE.
- Clean capture: set a_in=0x0F, b_in=0x03 and hold → start is high for one cycle exactly 4 edges after the first-sight edge; a_out=0x0F, b_out=0x03, launches=1. Pulse done 3 cycles later → busy=0 on the next edge.
- Glitch filter: a_in=0x0F for 2 cycles, then 0x10 held → the counter restarts and start fires 4 edges after 0x10 is first seen, with a_out=0x10. A toggle that returns to the held value mid-settle → no start.
- Lock: raise lock_in during SETTLE → IDLE, no start. Change inputs while lock_in=1 → no start and changed=1. Drop lock_in → capture begins with normal latency.
- BUSY behaviour: change inputs during BUSY → a_out unchanged and changed=1. done asserted together with start → ignored, busy stays 1. done one cycle later → IDLE, after which the pending change settles and relaunches.
- Wrap and SETTLE=0 (CNT_W=2, SETTLE=0): perform 5 launches → launches goes 1,2,3,0,1. Each launch fires on the first-sight edge with a_out equal to a_in at that edge.
